// File: rtl/dmux_word_collector.sv
// Collects the serial bits leaving a 1:2 bit demux into per-channel words,
// buffers one completed word per channel and presents them on a valid/ready port.
module dmux_word_collector #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_vld,
    input  logic              s,
    input  logic              y0,
    input  logic              y1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_chan,
    output logic [WORD_W-1:0] out_data,
    output logic              overrun,
    output logic              ovr_chan
);

    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);

    function automatic logic [WORD_W-1:0] insert_bit(
        input logic [WORD_W-1:0] word,
        input logic [CW-1:0]     pos,
        input logic              b
    );
        logic [WORD_W-1:0] r;
        r      = word;
        r[pos] = b;
        return r;
    endfunction

    logic [WORD_W-1:0] shreg_r [2];
    logic [CW-1:0]     cnt_r   [2];
    logic [WORD_W-1:0] hold_r  [2];
    logic [1:0]        hold_vld_r;
    logic              rr_r;
    logic              out_valid_r;
    logic              out_chan_r;
    logic [WORD_W-1:0] out_data_r;
    logic              overrun_r;
    logic              ovr_chan_r;

    logic              bit_in_s;
    logic [WORD_W-1:0] cur_shreg_s;
    logic [CW-1:0]     cur_cnt_s;
    logic [CW-1:0]     next_cnt_s;
    logic [WORD_W-1:0] word_s;
    logic              complete_s;
    logic              can_load_s;
    logic              move_s;
    logic              move_ch_s;
    logic              hold_free_s;
    logic              store_s;
    logic              drop_s;
    logic [1:0]        move_vec_s;
    logic [1:0]        store_vec_s;

    // Capture path: select the active channel and build the word including this bit
    always_comb begin
        bit_in_s    = 1'b0;
        cur_shreg_s = '0;
        cur_cnt_s   = '0;
        if (s) begin
            bit_in_s    = y1;
            cur_shreg_s = shreg_r[1];
            cur_cnt_s   = cnt_r[1];
        end else begin
            bit_in_s    = y0;
            cur_shreg_s = shreg_r[0];
            cur_cnt_s   = cnt_r[0];
        end
        word_s     = insert_bit(cur_shreg_s, cur_cnt_s, bit_in_s);
        complete_s = bit_vld && (cur_cnt_s == CNT_LAST);
        if (complete_s) begin
            next_cnt_s = '0;
        end else begin
            next_cnt_s = cur_cnt_s + CW'(1);
        end
    end

    // Output-stage arbitration; rr points away from the most recently granted channel
    always_comb begin
        move_s     = 1'b0;
        move_ch_s  = 1'b0;
        can_load_s = !out_valid_r || out_ready;
        if (can_load_s && (hold_vld_r == 2'b11)) begin
            move_s    = 1'b1;
            move_ch_s = rr_r;
        end else if (can_load_s && hold_vld_r[0]) begin
            move_s    = 1'b1;
            move_ch_s = 1'b0;
        end else if (can_load_s && hold_vld_r[1]) begin
            move_s    = 1'b1;
            move_ch_s = 1'b1;
        end else begin
            move_s    = 1'b0;
            move_ch_s = 1'b0;
        end
    end

    // A completion may land in a hold that is being emptied on the same edge
    always_comb begin
        hold_free_s = !hold_vld_r[s] || (move_s && (move_ch_s == s));
        store_s     = complete_s && hold_free_s;
        drop_s      = complete_s && !hold_free_s;
        if (move_s) begin
            move_vec_s = move_ch_s ? 2'b10 : 2'b01;
        end else begin
            move_vec_s = 2'b00;
        end
        if (store_s) begin
            store_vec_s = s ? 2'b10 : 2'b01;
        end else begin
            store_vec_s = 2'b00;
        end
    end

    // Per-channel shift registers and bit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                shreg_r[i] <= '0;
                cnt_r[i]   <= '0;
            end
        end else if (bit_vld) begin
            shreg_r[s] <= word_s;
            cnt_r[s]   <= next_cnt_s;
        end
    end

    // Hold buffers: a store wins over a move of the same channel on one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                hold_r[i] <= '0;
            end
            hold_vld_r <= 2'b00;
        end else begin
            if (store_s) begin
                hold_r[s] <= word_s;
            end
            hold_vld_r <= (hold_vld_r & ~move_vec_s) | store_vec_s;
        end
    end

    // Output register, round-robin pointer and overrun reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_chan_r  <= 1'b0;
            out_data_r  <= '0;
            rr_r        <= 1'b0;
            overrun_r   <= 1'b0;
            ovr_chan_r  <= 1'b0;
        end else begin
            if (move_s) begin
                out_valid_r <= 1'b1;
                out_chan_r  <= move_ch_s;
                out_data_r  <= move_ch_s ? hold_r[1] : hold_r[0];
                rr_r        <= ~move_ch_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            overrun_r <= drop_s;
            if (drop_s) begin
                ovr_chan_r <= s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;
    assign out_data  = out_data_r;
    assign overrun   = overrun_r;
    assign ovr_chan  = ovr_chan_r;

endmodule

// File: tb/tb_dmux_word_collector.sv
// Directed bench for dmux_word_collector: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares each accepted word.
module tb_dmux_word_collector;

    logic       clk;
    logic       rst_n;
    logic       bit_vld;
    logic       s;
    logic       y0;
    logic       y1;
    logic       out_valid;
    logic       out_ready;
    logic       out_chan;
    logic [7:0] out_data;
    logic       overrun;
    logic       ovr_chan;

    int          asserts;
    int          fails;
    int          ovr_seen;
    logic [31:0] exp_q[$];
    logic        prev_hold;
    logic [31:0] prev_word;
    logic [31:0] popped;

    dmux_word_collector #(.WORD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld), .s(s), .y0(y0), .y1(y1),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_data(out_data), .overrun(overrun), .ovr_chan(ovr_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks stability under backpressure
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                check("hold_stable_valid", {31'd0, out_valid}, 32'd1);
                check("hold_stable_word", {23'd0, out_chan, out_data}, prev_word);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", {out_chan, out_data});
                end else begin
                    popped = exp_q.pop_front();
                    check("word", {23'd0, out_chan, out_data}, popped);
                end
            end
            if (overrun) ovr_seen++;
            prev_hold = out_valid && !out_ready;
            prev_word = {23'd0, out_chan, out_data};
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic ch, input logic b);
        s       = ch;
        y0      = ch ? ~b : b;
        y1      = ch ? b : ~b;
        bit_vld = 1'b1;
        step();
        bit_vld = 1'b0;
    endtask

    task automatic send_word(input logic ch, input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(ch, w[i]);
    endtask

    task automatic push(input logic ch, input logic [7:0] w);
        exp_q.push_back({23'd0, ch, w});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        asserts = 0; fails = 0; ovr_seen = 0; prev_hold = 1'b0; prev_word = '0;
        rst_n = 1'b0; bit_vld = 1'b0; s = 1'b0; y0 = 1'b0; y1 = 1'b0; out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_overrun", {30'd0, overrun, ovr_chan}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: single ch0 word and its latency
        push(1'b0, 8'h4D);
        send_word(1'b0, 8'h4D);
        check("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_word", {23'd0, out_chan, out_data}, 32'h04D);
        step();
        check("t1_one_cycle", {31'd0, out_valid}, 32'd0);
        wait_drain();

        // 2: interleaved channels, completion order ch0 then ch1
        push(1'b0, 8'hFF);
        push(1'b1, 8'h55);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0, 1'b1);
            send_bit(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        wait_drain();

        // 3: backpressure, round-robin drain ch0, ch1, ch0
        out_ready = 1'b0;
        push(1'b0, 8'h3C); push(1'b1, 8'h81); push(1'b0, 8'h96);
        send_word(1'b0, 8'h3C);
        send_word(1'b1, 8'h81);
        send_word(1'b0, 8'h96);
        step();
        check("t3_presented", {23'd0, out_chan, out_data}, 32'h03C);
        out_ready = 1'b1;
        wait_drain();
        check("t3_no_overrun", ovr_seen, 32'd0);

        // 4: third word on a full channel is dropped, once per channel
        for (int c = 0; c < 2; c++) begin
            out_ready = 1'b0;
            push(c[0], 8'h11 + 8'(c));
            push(c[0], 8'h22 + 8'(c));
            send_word(c[0], 8'h11 + 8'(c));
            send_word(c[0], 8'h22 + 8'(c));
            send_word(c[0], 8'h33 + 8'(c));
            check("t4_overrun_pulse", {31'd0, overrun}, 32'd1);
            check("t4_ovr_chan", {31'd0, ovr_chan}, {31'd0, c[0]});
            check("t4_word1_kept", {24'd0, out_data}, {24'd0, 8'h11 + 8'(c)});
            step();
            check("t4_pulse_end", {31'd0, overrun}, 32'd0);
            check("t4_ovr_chan_held", {31'd0, ovr_chan}, {31'd0, c[0]});
            out_ready = 1'b1;
            wait_drain();
        end
        check("t4_overrun_count", ovr_seen, 32'd2);

        // 5: asynchronous reset mid-word discards everything
        out_ready = 1'b0;
        send_word(1'b0, 8'h77);
        step();
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
        check("t5_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", {31'd0, out_valid}, 32'd0);
        check("t5_async_word", {23'd0, out_chan, out_data}, 32'd0);
        check("t5_async_ovr", {30'd0, overrun, ovr_chan}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        push(1'b1, 8'hA5);
        send_word(1'b1, 8'hA5);
        wait_drain();

        // 6: no capture while bit_vld is low
        for (int i = 0; i < 20; i++) begin
            s = i[0]; y0 = i[1]; y1 = ~i[0];
            step();
            check("t6_idle_valid", {31'd0, out_valid}, 32'd0);
        end
        push(1'b0, 8'h5A);
        send_word(1'b0, 8'h5A);
        wait_drain();
        check("final_overrun_count", ovr_seen, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
